// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, widths and frame helpers
package uart_pkg;
  localparam int BAUD_W = 19;
  typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;
  function automatic logic [3:0] nb(input logic eight, input logic pen);
    return 4'd8 + {3'b0, eight} + {3'b0, pen};
  endfunction
  function automatic logic par(input logic [7:0] d, input logic eight, input logic ohel);
    return ohel ^ (^(d & {eight, 7'h7f}));
  endfunction
endpackage

// File: rtl/uart_receive_if.sv
// uart_receive_if: serial line, frame config and processor read port of the receiver
interface uart_receive_if;
  import uart_pkg::*;
  logic RX;
  logic PEN;
  logic OHEL;
  logic EIGHT;
  logic [BAUD_W-1:0] BAUD_COUNT;
  logic CLR;
  logic [7:0] RX_DATA;
  logic RXRDY;
  logic PERR;
  logic FERR;
  logic OVF;
  modport master (output RX, PEN, OHEL, EIGHT, BAUD_COUNT, CLR, input RX_DATA, RXRDY, PERR, FERR, OVF);
  modport slave (input RX, PEN, OHEL, EIGHT, BAUD_COUNT, CLR, output RX_DATA, RXRDY, PERR, FERR, OVF);
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period counter 0..i_baud with terminal and half-period strobes
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [BAUD_W-1:0] i_baud,
  output logic              o_term,
  output logic              o_half
);
  logic [BAUD_W-1:0] r_cnt;
  assign o_term = r_cnt == i_baud;
  assign o_half = r_cnt == (i_baud >> 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= o_term ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/uart_receive.sv
// uart_receive: UART receiver with RXRDY/CLR read port; define RX_MAJORITY_FILTER_EN for 2-of-3 majority sampling
module uart_receive
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic reset,
  uart_receive_if.slave bus
);
  logic [SYNC_STAGES-1:0] r_sync;
  state_t r_state, w_next;
  logic [3:0] r_bitcnt, r_nb;
  logic r_pen, r_ohel, r_eight, r_armed;
  logic [9:0] r_sh, w_fr;
  logic [7:0] r_data, w_d;
  logic r_rdy, r_perr, r_ferr, r_ovf;
  logic w_rx, w_start, w_clr, w_term, w_half, w_hit, w_bit, w_go, w_restart, w_stop, w_pbit;
  assign w_rx = r_sync[SYNC_STAGES-1];
  assign w_start = r_state == IDLE && r_armed && !w_rx;
  uart_bit_timer u_timer (
    .clk(clk), .reset(reset), .i_clr(w_clr), .i_en(1'b1), .i_baud(bus.BAUD_COUNT),
    .o_term(w_term), .o_half(w_half)
  );
`ifdef RX_MAJORITY_FILTER_EN
  // Samples at half-1 and half are kept in r_hist; the vote completes one clock after half.
  logic [1:0] r_hist;
  logic r_half_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_hist <= '1;
      r_half_d <= 1'b0;
    end else begin
      r_hist <= {r_hist[0], w_rx};
      r_half_d <= w_half;
    end
  assign w_hit = r_half_d;
  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx) | (r_hist[0] & w_rx);
  assign w_go = w_term;
  assign w_restart = 1'b0;
`else
  assign w_hit = (r_state == START) ? w_half : w_term;
  assign w_bit = w_rx;
  assign w_go = w_hit & ~w_rx;
  assign w_restart = 1'b1;
`endif
  assign w_fr = r_sh >> (4'd10 - r_nb);
  assign w_d = {r_eight & w_fr[7], w_fr[6:0]};
  assign w_pbit = r_eight ? w_fr[8] : w_fr[7];
  assign w_stop = w_fr[r_nb - 4'd1];
  always_comb begin
    w_next = r_state;
    w_clr = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_clr = 1'b1;
        w_next = w_start ? START : IDLE;
      end
      START:
        if (w_hit && w_bit) w_next = IDLE;
        else if (w_go) begin
          w_next = DATA;
          w_clr = w_restart;
        end
      DATA: w_next = (w_hit && r_bitcnt + 4'd1 == r_nb) ? DONE : DATA;
      DONE: begin
        w_clr = 1'b1;
        w_next = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_sync <= '1;
      r_state <= IDLE;
      r_bitcnt <= '0;
      r_nb <= 4'd8;
      r_pen <= 1'b0;
      r_ohel <= 1'b0;
      r_eight <= 1'b0;
      r_armed <= 1'b1;
      r_sh <= '0;
      r_data <= '0;
      r_rdy <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.RX};
      r_state <= w_next;
      if (w_start) begin
        r_pen <= bus.PEN;
        r_ohel <= bus.OHEL;
        r_eight <= bus.EIGHT;
        r_nb <= nb(bus.EIGHT, bus.PEN);
      end
      r_bitcnt <= (r_state == DATA) ? r_bitcnt + {3'b0, w_hit} : '0;
      if (r_state == DATA && w_hit) r_sh <= {w_bit, r_sh[9:1]};
      // A break (stop bit low) disarms start detection until the line idles high again.
      r_armed <= w_rx | (r_armed & ~(r_state == DONE & ~w_stop));
      if (r_state == DONE) begin
        r_data <= w_d;
        r_perr <= r_pen & (w_pbit != par(w_d, r_eight, r_ohel));
        r_ferr <= ~w_stop;
        r_rdy <= 1'b1;
        r_ovf <= r_ovf | (r_rdy & ~bus.CLR);
      end else if (bus.CLR) begin
        r_rdy <= 1'b0;
        r_ovf <= 1'b0;
      end
    end
  assign bus.RX_DATA = r_data;
  assign bus.RXRDY = r_rdy;
  assign bus.PERR = r_perr;
  assign bus.FERR = r_ferr;
  assign bus.OVF = r_ovf;
endmodule

// File: tb/tb_uart_receive.sv
// tb_uart_receive: vector table, random frames vs a frame-level model, and handshake/break/reset sequences
module tb_uart_receive;
  import uart_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  int b = 9;
  always #5 clk = ~clk;
  uart_receive_if bus();
  uart_receive #(.SYNC_STAGES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [7:0] d;
    logic e, p, o, flip, stop;
    logic [7:0] xd;
    logic xp, xf;
  } vec_t;
  vec_t tv[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Drives one frame LSB first; leaves the line low afterwards if the stop bit is 0.
  task automatic send(input logic [7:0] d, input logic e, input logic p, input logic o,
                      input logic flip, input logic stop);
    int ones;
    @(negedge clk);
    bus.RX = 1'b0;
    repeat (b + 1) @(negedge clk);
    for (int i = 0; i < 7 + int'(e); i++) begin
      bus.RX = d[i];
      repeat (b + 1) @(negedge clk);
    end
    if (p) begin
      ones = $countones(e ? d : {1'b0, d[6:0]});
      bus.RX = (o ? (ones % 2 == 0) : (ones % 2 == 1)) ^ flip;
      repeat (b + 1) @(negedge clk);
    end
    bus.RX = stop;
    repeat (b + 1) @(negedge clk);
    if (stop) bus.RX = 1'b1;
  endtask
  task automatic wait_rdy(input string name);
    int k = 0;
    while (!bus.RXRDY && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'b0, bus.RXRDY}, 1);
  endtask
  task automatic do_clr();
    @(negedge clk);
    bus.CLR = 1'b1;
    @(negedge clk);
    bus.CLR = 1'b0;
  endtask
  task automatic cfg(input logic e, input logic p, input logic o);
    bus.EIGHT = e;
    bus.PEN = p;
    bus.OHEL = o;
  endtask
  task automatic chk_zero(input string name);
    chk({name, "_data"}, {24'b0, bus.RX_DATA}, 0);
    chk({name, "_rdy"}, {31'b0, bus.RXRDY}, 0);
    chk({name, "_perr"}, {31'b0, bus.PERR}, 0);
    chk({name, "_ferr"}, {31'b0, bus.FERR}, 0);
    chk({name, "_ovf"}, {31'b0, bus.OVF}, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] d, xd;
    logic e, p, o, flip, stop;
    int k;
    tv[0] = '{8'hA5, 1, 1, 0, 0, 1, 8'hA5, 0, 0};
    tv[1] = '{8'h41, 0, 1, 1, 1, 1, 8'h41, 1, 0};
    tv[2] = '{8'h41, 0, 1, 1, 0, 1, 8'h41, 0, 0};
    tv[3] = '{8'h3C, 1, 0, 0, 0, 1, 8'h3C, 0, 0};
    tv[4] = '{8'hC3, 0, 0, 0, 0, 1, 8'h43, 0, 0};
    tv[5] = '{8'h55, 1, 1, 1, 1, 0, 8'h55, 1, 1};
    tv[6] = '{8'hFF, 1, 1, 0, 0, 1, 8'hFF, 0, 0};
    tv[7] = '{8'h80, 0, 1, 0, 1, 1, 8'h00, 1, 0};
    bus.RX = 1'b1;
    bus.CLR = 1'b0;
    bus.BAUD_COUNT = BAUD_W'(b);
    cfg(1, 1, 0);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    repeat (5) @(negedge clk);
    foreach (tv[i]) begin
      cfg(tv[i].e, tv[i].p, tv[i].o);
      send(tv[i].d, tv[i].e, tv[i].p, tv[i].o, tv[i].flip, tv[i].stop);
      bus.RX = 1'b1;
      wait_rdy($sformatf("vec%0d_rdy", i));
      chk($sformatf("vec%0d_data", i), {24'b0, bus.RX_DATA}, {24'b0, tv[i].xd});
      chk($sformatf("vec%0d_perr", i), {31'b0, bus.PERR}, {31'b0, tv[i].xp});
      chk($sformatf("vec%0d_ferr", i), {31'b0, bus.FERR}, {31'b0, tv[i].xf});
      chk($sformatf("vec%0d_ovf", i), {31'b0, bus.OVF}, 0);
      do_clr();
      chk($sformatf("vec%0d_clr", i), {31'b0, bus.RXRDY}, 0);
      repeat (3) @(negedge clk);
    end
    cfg(1, 1, 0);
    fork
      send(8'hB7, 1, 1, 0, 0, 1);
      begin
        repeat (30) @(negedge clk);
        cfg(0, 0, 1);
      end
    join
    wait_rdy("latch_rdy");
    chk("latch_data", {24'b0, bus.RX_DATA}, 32'hB7);
    chk("latch_perr", {31'b0, bus.PERR}, 0);
    do_clr();
    cfg(1, 0, 0);
    @(negedge clk);
    bus.RX = 1'b0;
    repeat (3) @(negedge clk);
    bus.RX = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_rdy", {31'b0, bus.RXRDY}, 0);
    send(8'h3C, 1, 0, 0, 0, 1);
    wait_rdy("glitch_next_rdy");
    chk("glitch_next_data", {24'b0, bus.RX_DATA}, 32'h3C);
    do_clr();
    cfg(1, 1, 0);
    send(8'h11, 1, 1, 0, 0, 1);
    send(8'h22, 1, 1, 0, 0, 1);
    wait_rdy("b2b_rdy");
    chk("b2b_data", {24'b0, bus.RX_DATA}, 32'h22);
    chk("b2b_ovf", {31'b0, bus.OVF}, 1);
    do_clr();
    chk("b2b_clr_ovf", {31'b0, bus.OVF}, 0);
    chk("b2b_clr_rdy", {31'b0, bus.RXRDY}, 0);
    send(8'h33, 1, 1, 0, 0, 1);
    wait_rdy("pre_done_rdy");
    k = 2 + 2 + (b >> 1) + 10 * (b + 1);
    fork
      send(8'h44, 1, 1, 0, 0, 1);
      begin
        repeat (k + 1) @(negedge clk);
        bus.CLR = 1'b1;
        @(negedge clk);
        bus.CLR = 1'b0;
      end
    join
    chk("clr_done_rdy", {31'b0, bus.RXRDY}, 1);
    chk("clr_done_ovf", {31'b0, bus.OVF}, 0);
    chk("clr_done_data", {24'b0, bus.RX_DATA}, 32'h44);
    do_clr();
    cfg(1, 0, 0);
    send(8'h55, 1, 0, 0, 0, 0);
    wait_rdy("break_rdy");
    chk("break_ferr", {31'b0, bus.FERR}, 1);
    chk("break_data", {24'b0, bus.RX_DATA}, 32'h55);
    do_clr();
    repeat (30 * (b + 1)) @(negedge clk);
    chk("break_hold_rdy", {31'b0, bus.RXRDY}, 0);
    bus.RX = 1'b1;
    repeat (20) @(negedge clk);
    send(8'h5A, 1, 0, 0, 0, 1);
    wait_rdy("break_next_rdy");
    chk("break_next_data", {24'b0, bus.RX_DATA}, 32'h5A);
    chk("break_next_ferr", {31'b0, bus.FERR}, 0);
    fork
      send(8'h99, 1, 0, 0, 0, 1);
      begin
        repeat (40) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_zero("midreset");
      end
    join
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h66, 1, 0, 0, 0, 1);
    wait_rdy("post_reset_rdy");
    chk("post_reset_data", {24'b0, bus.RX_DATA}, 32'h66);
    chk("post_reset_ferr", {31'b0, bus.FERR}, 0);
    chk("post_reset_perr", {31'b0, bus.PERR}, 0);
    chk("post_reset_ovf", {31'b0, bus.OVF}, 0);
    do_clr();
    for (int i = 0; i < 25; i++) begin
      b = int'($urandom_range(3, 15));
      bus.BAUD_COUNT = BAUD_W'(b);
      d = 8'($urandom);
      {e, p, o, flip} = 4'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      cfg(e, p, o);
      repeat (3) @(negedge clk);
      send(d, e, p, o, flip, stop);
      bus.RX = 1'b1;
      xd = e ? d : 8'(d % 128);
      wait_rdy($sformatf("rnd%0d_rdy", i));
      chk($sformatf("rnd%0d_data", i), {24'b0, bus.RX_DATA}, {24'b0, xd});
      chk($sformatf("rnd%0d_perr", i), {31'b0, bus.PERR}, {31'b0, p & flip});
      chk($sformatf("rnd%0d_ferr", i), {31'b0, bus.FERR}, {31'b0, !stop});
      do_clr();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
